// File: rtl/imu_pkg.sv
// Shared types and default timing for the IMU SPI arbiter.
package imu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BUSY,
        ST_DRAIN,
        ST_GAP
    } arb_state_t;

    // 20 us of bus silence at 125 MHz between register transactions
    localparam logic [15:0] GAP_CYCLES_DEF     = 16'd2500;
    // 2 ms ceiling on a single granted transaction
    localparam logic [19:0] TIMEOUT_CYCLES_DEF = 20'd250000;
    localparam logic [3:0]  MAX_DEFER_DEF      = 4'd4;

    // one counter serves both GAP and timeout, so it is sized for the larger
    localparam int TMR_W = 20;

    localparam logic OWN_SAMPLER = 1'b0;
    localparam logic OWN_HOST    = 1'b1;

    typedef struct packed {
        logic [7:0] idx;
        logic [7:0] len;
        logic [7:0] start_word;
    } reg_desc_t;

endpackage

// File: rtl/imu_arb_timer.sv
// Free-running cycle counter with clear, enable and terminal-count compare.
module imu_arb_timer
    import imu_pkg::*;
(
    input  logic             c,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [TMR_W-1:0] term,
    output logic             hit
);

    logic [TMR_W-1:0] cnt;

    // count enabled cycles; clear wins so every state starts from zero
    always_ff @(posedge c) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hit = en && (cnt == term);

endmodule

// File: rtl/imu_spi_arbiter.sv
// Two-requester arbiter (sampler, host) in front of one shared SPI register
// reader, with bounded host starvation, a transaction timeout and a forced
// idle gap between transactions.
module imu_spi_arbiter
    import imu_pkg::*;
#(
    parameter logic [15:0] GAP_CYCLES     = GAP_CYCLES_DEF,
    parameter logic [19:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter logic [3:0]  MAX_DEFER      = MAX_DEFER_DEF
) (
    input  logic        c,
    input  logic        rst_n,
    // sampler
    input  logic        s_req,
    input  logic [7:0]  s_idx,
    input  logic [7:0]  s_len,
    input  logic [7:0]  s_start_word,
    output logic        s_done,
    output logic        s_err,
    output logic        s_dv,
    output logic [31:0] s_d,
    // host configuration path
    input  logic        h_req,
    input  logic [7:0]  h_idx,
    input  logic [7:0]  h_len,
    input  logic [7:0]  h_start_word,
    output logic        h_done,
    output logic        h_err,
    output logic        h_dv,
    output logic [31:0] h_d,
    // shared register reader
    output logic        rr_start,
    output logic [7:0]  rr_idx,
    output logic [7:0]  rr_len,
    output logic [7:0]  rr_start_word,
    input  logic        rr_done,
    input  logic        rr_dv,
    input  logic [31:0] rr_d,
    // status
    output logic        busy,
    output logic        owner
);

    localparam logic [TMR_W-1:0] GAP_TERM =
        (GAP_CYCLES == 16'd0) ? '0 : TMR_W'(GAP_CYCLES - 16'd1);
    localparam logic [TMR_W-1:0] TMO_TERM =
        (TIMEOUT_CYCLES == 20'd0) ? '0 : TMR_W'(TIMEOUT_CYCLES - 20'd1);

    arb_state_t       state, state_nx;
    reg_desc_t        desc_q;
    logic             owner_q;
    logic [3:0]       defer_cnt;
    logic             rr_start_q;
    logic             grant_host;
    logic             tmr_clr, tmr_en, tmr_hit;
    logic [TMR_W-1:0] tmr_term;

    // host wins alone, or when the sampler has already beaten it MAX_DEFER times
    assign grant_host = h_req && (!s_req || (defer_cnt == MAX_DEFER));

    // state register, grant latch, starvation counter and the start strobe
    always_ff @(posedge c) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            desc_q     <= '0;
            owner_q    <= OWN_SAMPLER;
            defer_cnt  <= '0;
            rr_start_q <= 1'b0;
        end else begin
            state      <= state_nx;
            // start is registered out of START, giving req-to-start of 2 cycles
            rr_start_q <= (state == ST_START);
            if (state == ST_IDLE && (s_req || h_req)) begin
                owner_q <= grant_host;
                desc_q  <= grant_host ? reg_desc_t'{h_idx, h_len, h_start_word}
                                      : reg_desc_t'{s_idx, s_len, s_start_word};
                if (grant_host) begin
                    defer_cnt <= '0;
                end else if (h_req && defer_cnt != MAX_DEFER) begin
                    defer_cnt <= defer_cnt + 1'b1;
                end
            end
        end
    end

    // next state and completion strobes; rr_done on the timeout cycle counts as success
    always_comb begin
        state_nx = state;
        s_done   = 1'b0;
        h_done   = 1'b0;
        s_err    = 1'b0;
        h_err    = 1'b0;
        case (state)
            ST_IDLE:  if (s_req || h_req) state_nx = ST_START;
            ST_START: state_nx = ST_BUSY;
            ST_BUSY: begin
                if (rr_done || tmr_hit) begin
                    s_done   = (owner_q == OWN_SAMPLER);
                    h_done   = (owner_q == OWN_HOST);
                    s_err    = (owner_q == OWN_SAMPLER) && !rr_done;
                    h_err    = (owner_q == OWN_HOST) && !rr_done;
                    state_nx = rr_done ? ST_GAP : ST_DRAIN;
                end
            end
            ST_DRAIN: if (rr_done) state_nx = ST_GAP;
            ST_GAP:   if (tmr_hit) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // the timer restarts on every state change so BUSY and GAP both begin at zero
    assign tmr_clr  = (state_nx != state);
    assign tmr_en   = (state == ST_BUSY) || (state == ST_GAP);
    assign tmr_term = (state == ST_GAP) ? GAP_TERM : TMO_TERM;

    imu_arb_timer u_timer (
        .c     (c),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .term  (tmr_term),
        .hit   (tmr_hit)
    );

    assign rr_start      = rr_start_q;
    assign rr_idx        = desc_q.idx;
    assign rr_len        = desc_q.len;
    assign rr_start_word = desc_q.start_word;

    // data fans out unconditionally; only the owner's valid is opened, and only in BUSY
    assign s_d  = rr_d;
    assign h_d  = rr_d;
    assign s_dv = rr_dv && (state == ST_BUSY) && (owner_q == OWN_SAMPLER);
    assign h_dv = rr_dv && (state == ST_BUSY) && (owner_q == OWN_HOST);

    assign busy  = (state != ST_IDLE);
    assign owner = owner_q;

endmodule

// File: tb/tb_imu_spi_arbiter.sv
// Scoreboard bench for imu_spi_arbiter: stimulus pushes expected commands,
// data and completions; a negedge monitor pops and compares.
module tb_imu_spi_arbiter;

    localparam logic [15:0] GAP  = 16'd40;
    localparam logic [19:0] TMO  = 20'd300;
    localparam logic [3:0]  MAXD = 4'd4;

    logic        c = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_req = 1'b0, h_req = 1'b0;
    logic [7:0]  s_idx = '0, s_len = '0, s_sw = '0;
    logic [7:0]  h_idx = '0, h_len = '0, h_sw = '0;
    logic        s_done, s_err, s_dv, h_done, h_err, h_dv;
    logic [31:0] s_d, h_d;
    logic        rr_start;
    logic [7:0]  rr_idx, rr_len, rr_start_word;
    logic        rr_done = 1'b0, rr_dv = 1'b0;
    logic [31:0] rr_d = '0;
    logic        busy, owner;

    imu_spi_arbiter #(
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO),
        .MAX_DEFER      (MAXD)
    ) dut (
        .c             (c),
        .rst_n         (rst_n),
        .s_req         (s_req),
        .s_idx         (s_idx),
        .s_len         (s_len),
        .s_start_word  (s_sw),
        .s_done        (s_done),
        .s_err         (s_err),
        .s_dv          (s_dv),
        .s_d           (s_d),
        .h_req         (h_req),
        .h_idx         (h_idx),
        .h_len         (h_len),
        .h_start_word  (h_sw),
        .h_done        (h_done),
        .h_err         (h_err),
        .h_dv          (h_dv),
        .h_d           (h_d),
        .rr_start      (rr_start),
        .rr_idx        (rr_idx),
        .rr_len        (rr_len),
        .rr_start_word (rr_start_word),
        .rr_done       (rr_done),
        .rr_dv         (rr_dv),
        .rr_d          (rr_d),
        .busy          (busy),
        .owner         (owner)
    );

    always #5 c = ~c;

    int cyc = 0;
    always @(posedge c) cyc <= cyc + 1;

    typedef struct { bit own; bit [7:0] idx; bit [7:0] len; bit [7:0] sw; } cmd_t;
    typedef struct { bit own; bit [31:0] d; } dv_t;
    typedef struct { bit own; bit err; int at; } done_t;

    cmd_t  cmd_q[$];
    dv_t   dv_q[$];
    done_t done_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    // reference state: sampler wins over a waiting host, cycle GAP opened
    int m_defer    = 0;
    int last_gap_d = -100000;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic bail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    endtask

    task automatic step();
        @(posedge c);
        #1;
    endtask

    // monitor: every DUT-side event must match the head of its queue
    cmd_t  mc;
    dv_t   mv;
    done_t md;
    always @(negedge c) begin
        if (rr_start) begin
            if (cmd_q.size() == 0) chk("unexpected rr_start", 1, 0);
            else begin
                mc = cmd_q.pop_front();
                chk("grant owner", owner, mc.own);
                chk("rr_idx", rr_idx, mc.idx);
                chk("rr_len", rr_len, mc.len);
                chk("rr_start_word", rr_start_word, mc.sw);
            end
        end
        if (s_dv && h_dv) chk("both dv", 1, 0);
        if (s_dv || h_dv) begin
            if (dv_q.size() == 0) chk("unexpected dv", 1, 0);
            else begin
                mv = dv_q.pop_front();
                chk("dv owner", h_dv, mv.own);
                chk("dv data", h_dv ? h_d : s_d, mv.d);
            end
        end
        if (s_done && h_done) chk("both done", 1, 0);
        if (s_done || h_done) begin
            if (done_q.size() == 0) chk("unexpected done", 1, 0);
            else begin
                md = done_q.pop_front();
                chk("done owner", h_done, md.own);
                chk("done err", h_done ? h_err : s_err, md.err);
                chk("done cycle", cyc, md.at);
            end
        end else if (s_err || h_err) begin
            chk("err without done", 1, 0);
        end
    end

    // raise requests, predict the winner, wait for its rr_start and check timing
    task automatic grant(input bit ws, input bit wh, output bit win, output int r);
        cmd_t e;
        int   k;
        int   lim;
        int   idle_at;
        if (ws && !s_req) begin
            s_req = 1'b1; s_idx = 8'($urandom); s_len = 8'($urandom); s_sw = 8'($urandom);
        end
        if (wh && !h_req) begin
            h_req = 1'b1; h_idx = 8'($urandom); h_len = 8'($urandom); h_sw = 8'($urandom);
        end
        k = cyc;
        if (s_req && h_req) begin
            if (m_defer == int'(MAXD)) begin win = 1'b1; m_defer = 0; end
            else begin win = 1'b0; m_defer++; end
        end else if (h_req) begin
            win = 1'b1; m_defer = 0;
        end else begin
            win = 1'b0;
        end
        if (win) e = cmd_t'{1'b1, h_idx, h_len, h_sw};
        else     e = cmd_t'{1'b0, s_idx, s_len, s_sw};
        cmd_q.push_back(e);
        lim = 0;
        r = 0;
        @(negedge c);
        while (rr_start !== 1'b1) begin
            lim++;
            if (lim > 1000) begin bail("rr_start wait"); return; end
            @(negedge c);
        end
        r = cyc;
        // first IDLE cycle after the gap, then two cycles of request latency
        idle_at = last_gap_d + int'(GAP) + 1;
        chk("grant latency", r, ((k > idle_at) ? k : idle_at) + 2);
    endtask

    // mode 0: normal completion, 1: timeout then late done, 2: done on timeout cycle
    task automatic run_txn(input bit ws, input bit wh, input int ndv, input int mode,
                           input logic [31:0] fixed_d);
        bit win;
        int r;
        int d;
        grant(ws, wh, win, r);
        step();
        for (int i = 0; i < ndv; i++) begin
            rr_dv = 1'b1;
            rr_d  = (fixed_d != 0) ? fixed_d : $urandom;
            dv_q.push_back(dv_t'{win, rr_d});
            step();
            rr_dv = 1'b0;
            if ($urandom_range(1, 0) == 1) step();
        end
        if (mode == 1) begin
            done_q.push_back(done_t'{win, 1'b1, r + int'(TMO) - 1});
            while (cyc < r + int'(TMO) - 1) step();
            step();
            if (win) h_req = 1'b0; else s_req = 1'b0;
            repeat (5) step();
            rr_done = 1'b1; rr_dv = 1'b1; rr_d = $urandom;
            d = cyc;
        end else begin
            if (mode == 2) while (cyc < r + int'(TMO) - 1) step();
            else repeat ($urandom_range(5, 0)) step();
            rr_done = 1'b1;
            d = cyc;
            done_q.push_back(done_t'{win, 1'b0, d});
        end
        step();
        rr_done = 1'b0;
        rr_dv   = 1'b0;
        if (win) h_req = 1'b0; else s_req = 1'b0;
        last_gap_d = d;
        chk("owner holds", owner, win);
        chk("busy in gap", busy, 1);
    endtask

    initial begin
        bit win;
        int r;
        step();
        step();
        chk("reset busy", busy, 0);
        chk("reset owner", owner, 0);
        chk("reset rr_start", rr_start, 0);
        chk("reset done", {s_done, h_done, s_err, h_err, s_dv, h_dv}, 0);
        chk("reset rr_idx", rr_idx, 0);
        rst_n = 1'b1;

        // sampler read of register 54
        s_req = 1'b1; s_idx = 8'd54; s_len = 8'd11; s_sw = 8'd3;
        run_txn(1'b1, 1'b0, 0, 0, 32'd0);
        run_txn(1'b1, 1'b0, 1, 0, 32'd0);

        // host burst with fixed data
        run_txn(1'b0, 1'b1, 3, 0, 32'hDEADBEEF);

        // host starvation bound: four sampler grants, host on the fifth, sampler again
        for (int i = 0; i < 6; i++) run_txn(1'b1, 1'b1, $urandom_range(2, 0), 0, 32'd0);

        // rr_done exactly on the timeout cycle, then a real timeout
        run_txn(1'b0, 1'b1, 1, 2, 32'd0);
        run_txn(1'b1, 1'b0, 1, 1, 32'd0);

        // reset mid-transaction while the host owns the reader
        grant(1'b0, 1'b1, win, r);
        repeat (3) step();
        rst_n = 1'b0; s_req = 1'b0; h_req = 1'b0;
        step();
        rst_n = 1'b1;
        m_defer = 0;
        last_gap_d = -100000;
        chk("post-reset busy", busy, 0);
        chk("post-reset owner", owner, 0);
        step();
        rr_done = 1'b1; rr_dv = 1'b1; rr_d = 32'h1234_5678;
        step();
        rr_done = 1'b0; rr_dv = 1'b0;
        step();
        chk("stray done ignored", busy, 0);

        // random mix
        for (int i = 0; i < 20; i++) begin
            int sel;
            int mr;
            sel = $urandom_range(2, 0);
            mr  = $urandom_range(9, 0);
            run_txn(sel != 1, sel != 0, $urandom_range(3, 0),
                    (mr == 0) ? 1 : (mr == 1) ? 2 : 0, 32'd0);
        end
        s_req = 1'b0;
        h_req = 1'b0;
        repeat (int'(GAP) + 10) step();
        chk("final busy", busy, 0);
        chk("cmd queue drained", cmd_q.size(), 0);
        chk("dv queue drained", dv_q.size(), 0);
        chk("done queue drained", done_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // global watchdog
    initial begin
        #2000000;
        bail("global watchdog");
    end

endmodule
